// File: rtl/core_pkg.sv
// Shared pipeline types and constants for the hazard controller.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // True when a source operand that is actually read matches a nonzero destination.
  function automatic logic src_hits_rd(input logic                  uses,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] rd);
    return uses && (rd != '0) && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stall/flush controls out.
interface pipe_hazard_ctrl_if
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  wb_valid;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  ex_mem_stall;
  logic                  mem_wb_bubble;
  logic [1:0]            state_o;
  logic                  err_o;
  logic [CNT_W-1:0]      stall_cycles_o;
  logic [63:0]           retired_o;

  // Pipeline side: drives status, observes controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, wb_valid,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_bubble, state_o, err_o, stall_cycles_o, retired_o
  );

  // Controller side.
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, wb_valid,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_bubble, state_o, err_o, stall_cycles_o, retired_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_counters.sv
// Performance counters: saturating stall-cycle count and wrapping retire count.
module perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             retire_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [63:0]      retired
);

  logic [CNT_W-1:0] stall_q;
  logic [63:0]      retired_q;

  // Stall counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Retire counter wraps modulo 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire_inc) begin
      retired_q <= retired_q + 64'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign retired      = retired_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned TimerW = $clog2(MEM_TIMEOUT + 1);

  hazard_state_e     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic load_use;
  logic mem_wait;
  logic freeze;

  assign load_use = bus.ex_mem_read &&
                    (src_hits_rd(bus.id_uses_rs1, bus.id_rs1_addr, bus.ex_rd_addr) ||
                     src_hits_rd(bus.id_uses_rs2, bus.id_rs2_addr, bus.ex_rd_addr));
  assign mem_wait = bus.mem_req && !bus.mem_ready;
  assign freeze   = (state_q == ERROR) || mem_wait;

  // State and wait-timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state: enter wait on a stalled access, time it out into the absorbing error state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          timer_d = TimerW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TimerW'(MEM_TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  // Prioritised pipeline controls: freeze > branch squash > load-use stall.
  always_comb begin
    bus.pc_stall      = 1'b0;
    bus.if_id_stall   = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_stall   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_stall  = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (freeze) begin
        bus.pc_stall      = 1'b1;
        bus.if_id_stall   = 1'b1;
        bus.id_ex_stall   = 1'b1;
        bus.ex_mem_stall  = 1'b1;
        bus.mem_wb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
        // The ID instruction is squashed, so any load-use on it is moot.
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
      end else if (load_use) begin
        bus.pc_stall    = 1'b1;
        bus.if_id_stall = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
    end
  end

  assign bus.state_o = state_q;
  assign bus.err_o   = (state_q == ERROR);

  perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst         (rst),
    .stall_inc   (bus.pc_stall),
    .retire_inc  (bus.wb_valid),
    .stall_cycles(bus.stall_cycles_o),
    .retired     (bus.retired_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short timeout and narrow stall counter.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int unsigned TB_CNT_W   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(TB_TIMEOUT),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1_addr     = '0;
    bus.id_rs2_addr     = '0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_rd_addr      = '0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    bus.wb_valid        = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    // Memory stall presented during reset must not leak to the controls.
    bus.mem_req = 1'b1;
    #12;
    chk("rst_pc_stall", 64'(bus.pc_stall), 64'd0);
    chk("rst_bubble", 64'(bus.mem_wb_bubble), 64'd0);
    chk("rst_state", 64'(bus.state_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cycles_o), 64'd0);
    chk("rst_retired", bus.retired_o, 64'd0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Load-use on rs1: one-cycle stall.
    bus.ex_mem_read = 1'b1;
    bus.ex_rd_addr  = 5'd5;
    bus.id_rs1_addr = 5'd5;
    bus.id_uses_rs1 = 1'b1;
    #1;
    chk("lu_pc_stall", 64'(bus.pc_stall), 64'd1);
    chk("lu_if_id_stall", 64'(bus.if_id_stall), 64'd1);
    chk("lu_id_ex_flush", 64'(bus.id_ex_flush), 64'd1);
    chk("lu_id_ex_stall", 64'(bus.id_ex_stall), 64'd0);
    chk("lu_bubble", 64'(bus.mem_wb_bubble), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("lu_release", 64'(bus.pc_stall), 64'd0);
    chk("lu_stall_cnt", 64'(bus.stall_cycles_o), 64'd1);

    // x0 destination never creates a hazard.
    bus.ex_mem_read = 1'b1;
    bus.ex_rd_addr  = 5'd0;
    bus.id_rs1_addr = 5'd0;
    bus.id_uses_rs1 = 1'b1;
    #1;
    chk("x0_pc_stall", 64'(bus.pc_stall), 64'd0);
    chk("x0_id_ex_flush", 64'(bus.id_ex_flush), 64'd0);
    // rs2 path, then same match with the operand unused.
    bus.id_uses_rs1 = 1'b0;
    bus.ex_rd_addr  = 5'd7;
    bus.id_rs2_addr = 5'd7;
    bus.id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_pc_stall", 64'(bus.pc_stall), 64'd1);
    bus.id_uses_rs2 = 1'b0;
    #1;
    chk("rs2_unused", 64'(bus.pc_stall), 64'd0);

    // Branch beats a simultaneous load-use.
    bus.id_uses_rs2     = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("br_if_id_flush", 64'(bus.if_id_flush), 64'd1);
    chk("br_id_ex_flush", 64'(bus.id_ex_flush), 64'd1);
    chk("br_pc_stall", 64'(bus.pc_stall), 64'd0);
    chk("br_if_id_stall", 64'(bus.if_id_stall), 64'd0);
    clear_inputs();

    // Memory wait for 3 cycles, with a pending branch that must be ignored until release.
    pulse_reset();
    tick();
    bus.mem_req         = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("mw1_state", 64'(bus.state_o), 64'd0);
    chk("mw1_pc_stall", 64'(bus.pc_stall), 64'd1);
    chk("mw1_ex_mem_stall", 64'(bus.ex_mem_stall), 64'd1);
    chk("mw1_bubble", 64'(bus.mem_wb_bubble), 64'd1);
    chk("mw1_if_id_flush", 64'(bus.if_id_flush), 64'd0);
    tick();
    chk("mw2_state", 64'(bus.state_o), 64'd1);
    chk("mw2_id_ex_stall", 64'(bus.id_ex_stall), 64'd1);
    tick();
    chk("mw3_state", 64'(bus.state_o), 64'd1);
    chk("mw3_pc_stall", 64'(bus.pc_stall), 64'd1);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("mw4_state", 64'(bus.state_o), 64'd1);
    chk("mw4_pc_stall", 64'(bus.pc_stall), 64'd0);
    chk("mw4_bubble", 64'(bus.mem_wb_bubble), 64'd0);
    chk("mw4_if_id_flush", 64'(bus.if_id_flush), 64'd1);
    tick();
    clear_inputs();
    #1;
    chk("mw_back_run", 64'(bus.state_o), 64'd0);
    chk("mw_stall_cnt", 64'(bus.stall_cycles_o), 64'd3);

    // Ready in the same cycle as the request: no freeze, no wait state.
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("same_cyc_stall", 64'(bus.pc_stall), 64'd0);
    tick();
    chk("same_cyc_state", 64'(bus.state_o), 64'd0);
    clear_inputs();

    // Timeout: RUN cycle plus 4 MEM_WAIT cycles, then ERROR.
    pulse_reset();
    tick();
    bus.mem_req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) tick();
    chk("to_last_wait_state", 64'(bus.state_o), 64'd1);
    chk("to_last_wait_err", 64'(bus.err_o), 64'd0);
    tick();
    chk("to_error_state", 64'(bus.state_o), 64'd2);
    chk("to_error_err", 64'(bus.err_o), 64'd1);
    chk("to_stall_cnt5", 64'(bus.stall_cycles_o), 64'd5);
    bus.mem_ready = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("err_freeze", 64'(bus.pc_stall), 64'd1);
    chk("err_bubble", 64'(bus.mem_wb_bubble), 64'd1);
    chk("err_no_flush", 64'(bus.if_id_flush), 64'd0);
    tick();
    chk("err_sticky_state", 64'(bus.state_o), 64'd2);
    chk("err_sticky_err", 64'(bus.err_o), 64'd1);
    // 6 stall cycles so far; 14 more makes 20 and saturates a 4-bit counter.
    for (int i = 0; i < 14; i++) tick();
    chk("sat_stall_cnt", 64'(bus.stall_cycles_o), 64'd15);
    clear_inputs();
    pulse_reset();
    chk("clr_state", 64'(bus.state_o), 64'd0);
    chk("clr_err", 64'(bus.err_o), 64'd0);
    chk("clr_stall_cnt", 64'(bus.stall_cycles_o), 64'd0);

    // Reset asserted mid-wait aborts the wait at once.
    tick();
    bus.mem_req = 1'b1;
    tick();
    chk("midwait_state", 64'(bus.state_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("midwait_rst_state", 64'(bus.state_o), 64'd0);
    chk("midwait_rst_stall", 64'(bus.pc_stall), 64'd0);
    clear_inputs();
    #1;
    rst = 1'b0;
    tick();

    // Retire counter.
    bus.wb_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.wb_valid = 1'b0;
    tick();
    chk("retired_10", bus.retired_o, 64'd10);
    chk("retire_no_stall", 64'(bus.stall_cycles_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
